// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   Issue stage in front of a combinational ALU (op 00 add, 01 sub, 10 AND,
//   11 OR). Commands are buffered in a DEPTH-entry FIFO. The head is issued
//   into registered alu_a/alu_b/alu_op. The ALU result is captured one cycle
//   later and presented on a valid/ready output port. The ALU therefore sits
//   on a single register-to-register path.
//
//   Optional feature macro: ALU_ISSUE_FLAGS_EN adds the out_zero/out_carry flags.
//
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     in_valid/in_ready     command handshake (in_a, in_b, in_op)
//     alu_a/alu_b/alu_op    registered operands and opcode driving the ALU
//     alu_y                 ALU combinational result
//     out_valid/out_ready   result handshake (out_y, out_op)
//     count                 FIFO occupancy
//     out_zero/out_carry    result flags (ALU_ISSUE_FLAGS_EN only)
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [1:0]               in_op,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [1:0]               alu_op,
    input  logic [WIDTH-1:0]         alu_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_y,
    output logic [1:0]               out_op,
    output logic [$clog2(DEPTH):0]   count
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    output logic                     out_zero,
    output logic                     out_carry
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 2 * WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            capture;
    logic            release_out;

    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;

    // FSM next state. Pop decisions use the registered count, so a command
    // pushed on this edge cannot be issued before the next cycle.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                capture    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    if (count != '0) begin
                        pop        = 1'b1;
                        state_next = EXEC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Storage is not reset. Only the pointers and the occupancy define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_op, in_a, in_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef ALU_ISSUE_FLAGS_EN
    logic [WIDTH:0] sum_ext;
    logic           carry_calc;

    assign sum_ext = {1'b0, alu_a} + {1'b0, alu_b};

    always_comb begin
        carry_calc = 1'b0;
        case (alu_op)
            2'b00:   carry_calc = sum_ext[WIDTH];
            2'b01:   carry_calc = (alu_a < alu_b);
            default: carry_calc = 1'b0;
        endcase
    end
`endif

    // Issue and result registers. alu_* hold their last value in IDLE and DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            out_y     <= '0;
            out_op    <= '0;
            out_valid <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
            out_zero  <= 1'b0;
            out_carry <= 1'b0;
`endif
        end else begin
            if (pop) begin
                {alu_op, alu_a, alu_b} <= mem[rd_ptr];
            end
            if (capture) begin
                out_y     <= alu_y;
                out_op    <= alu_op;
                out_valid <= 1'b1;
`ifdef ALU_ISSUE_FLAGS_EN
                out_zero  <= (alu_y == '0);
                out_carry <= carry_calc;
`endif
            end else if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Testbench for alu_issue_queue. A behavioural ALU closes the alu_* loop.
// Each accepted command pushes its hand-computed result into a scoreboard.
// A monitor pops and compares on every out_valid/out_ready handshake.
module tb_alu_issue_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [1:0] in_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_op;
    logic [7:0] alu_y;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic [1:0] out_op;
    logic [2:0] count;
`ifdef ALU_ISSUE_FLAGS_EN
    logic       out_zero;
    logic       out_carry;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] op;
        logic [7:0] y;
        logic       z;
        logic       c;
    } exp_t;

    exp_t exp_q[$];

    alu_issue_queue #(.DEPTH(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_y     (alu_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_op    (out_op),
        .count     (count)
`ifdef ALU_ISSUE_FLAGS_EN
        ,
        .out_zero  (out_zero),
        .out_carry (out_carry)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            2'b00:   alu_y = alu_a + alu_b;
            2'b01:   alu_y = alu_a - alu_b;
            2'b10:   alu_y = alu_a & alu_b;
            default: alu_y = alu_a | alu_b;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got y=0x%0h op=%0d with empty scoreboard", out_y, out_op);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_y", 32'(out_y), 32'(e.y));
                check("out_op", 32'(out_op), 32'(e.op));
`ifdef ALU_ISSUE_FLAGS_EN
                check("out_zero", 32'(out_zero), 32'(e.z));
                check("out_carry", 32'(out_carry), 32'(e.c));
`endif
            end
        end
    end

    // Called at posedge+1. Holds in_valid until accepted and returns at posedge+1.
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic [7:0] y, input logic z, input logic c);
        bit acc;
        exp_t e;
        acc = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc) begin
            e.op = op; e.y = y; e.z = z; e.c = c;
            exp_q.push_back(e);
        end else begin
            checks++;
            failures++;
            $display("FAIL push_timeout: got in_ready=0 expected 1 within 40 cycles");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (exp_q.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("drain_count", 32'(count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_op = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single add and latency.
        out_ready = 1'b1;
        push(8'h7F, 8'h01, 2'b00, 8'h80, 1'b0, 1'b0);
        check("lat_count_after_accept", 32'(count), 32'd1);
        check("lat_valid_t0", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_issue_alu_a", 32'(alu_a), 32'h7F);
        check("lat_issue_alu_b", 32'(alu_b), 32'h01);
        check("lat_valid_t1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_valid_t2", 32'(out_valid), 32'd1);
        check("lat_out_y", 32'(out_y), 32'h80);
        drain();

        // Subtract wrap.
        push(8'h00, 8'h01, 2'b01, 8'hFF, 1'b0, 1'b1);
        drain();

        // Backpressure and full.
        out_ready = 1'b0;
        push(8'h01, 8'h02, 2'b00, 8'h03, 1'b0, 1'b0);
        push(8'h05, 8'h03, 2'b01, 8'h02, 1'b0, 1'b0);
        push(8'h0F, 8'h3C, 2'b10, 8'h0C, 1'b0, 1'b0);
        push(8'h50, 8'h05, 2'b11, 8'h55, 1'b0, 1'b0);
        push(8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1'b1);
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_a = 8'h10;
        in_b = 8'h10;
        in_op = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall_count_held", 32'(count), 32'd4);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_y", 32'(out_y), 32'h03);
        end
        out_ready = 1'b1;
        push(8'h10, 8'h10, 2'b01, 8'h00, 1'b1, 1'b0);
        drain();

        // Ordering.
        push(8'h10, 8'h20, 2'b00, 8'h30, 1'b0, 1'b0);
        push(8'hF0, 8'h3C, 2'b10, 8'h30, 1'b0, 1'b0);
        push(8'h0F, 8'hA0, 2'b11, 8'hAF, 1'b0, 1'b0);
        drain();
        check("hold_alu_a_idle", 32'(alu_a), 32'h0F);
        check("hold_alu_op_idle", 32'(alu_op), 32'd3);

        // Simultaneous push and pop with count=2 in DONE.
        out_ready = 1'b0;
        push(8'h11, 8'h22, 2'b00, 8'h33, 1'b0, 1'b0);
        push(8'h80, 8'h80, 2'b00, 8'h00, 1'b1, 1'b1);
        push(8'h40, 8'h01, 2'b01, 8'h3F, 1'b0, 1'b0);
        check("sim_pre_count", 32'(count), 32'd2);
        check("sim_pre_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        push(8'hCC, 8'h0F, 2'b10, 8'h0C, 1'b0, 1'b0);
        check("sim_count_stays", 32'(count), 32'd2);
        check("sim_reissued", 32'(out_valid), 32'd0);
        check("sim_alu_a", 32'(alu_a), 32'h80);
        drain();

        // Reset mid-operation.
        out_ready = 1'b0;
        push(8'h01, 8'h01, 2'b00, 8'h02, 1'b0, 1'b0);
        push(8'h09, 8'h04, 2'b01, 8'h05, 1'b0, 1'b0);
        push(8'h33, 8'h0F, 2'b10, 8'h03, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("rstmid_in_exec_count", 32'(count), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        check("rstmid_count", 32'(count), 32'd0);
        check("rstmid_in_ready", 32'(in_ready), 32'd1);
        check("rstmid_alu_a", 32'(alu_a), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("rstmid_no_stale", 32'(out_valid), 32'd0);
        end
        push(8'hC0, 8'h40, 2'b00, 8'h00, 1'b1, 1'b1);
        drain();

        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
